// File: rtl/osd_dp_trace_packetizer_if.sv
// Event flit link: one 16-bit flit per valid&ready handshake, last marks packet end.
interface osd_dp_trace_packetizer_if;
  logic        valid;
  logic        last;
  logic [15:0] data;
  logic        ready;

  modport master (output valid, output last, output data, input  ready);
  modport slave  (input  valid, input  last, input  data, output ready);
endinterface

// File: rtl/osd_dp_trace_packetizer.sv
// Trace event packetizer: arbitrates per-channel trace strobes into an event FIFO
// and serializes each entry as an 8-flit (for XLEN=64) debug-interconnect packet.
module osd_dp_trace_packetizer #(
  parameter int XLEN  = 64,
  parameter int NCH   = 4,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [9:0]             id,
  input  logic [NCH-1:0]         trace_valid,
  input  logic [16*NCH-1:0]      trace_id,
  input  logic [XLEN*NCH-1:0]    trace_value,
  input  logic                   reg_request,
  input  logic                   reg_write,
  input  logic [15:0]            reg_addr,
  input  logic [15:0]            reg_wdata,
  output logic                   reg_ack,
  output logic                   reg_err,
  output logic [15:0]            reg_rdata,
  osd_dp_trace_packetizer_if.master event_out
);

  localparam int NW  = XLEN / 16;
  localparam int WW  = (NW > 1) ? $clog2(NW) : 1;
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [CHW-1:0]  ch;
    logic [15:0]     tid;
    logic [XLEN-1:0] val;
  } ev_t;

  typedef enum logic [2:0] {S_IDLE, S_DEST, S_SRC, S_TYPE, S_TID, S_VAL} state_t;

  // ---------------- register file ----------------
  logic           en_q;
  logic [NCH-1:0] mask_q;
  logic [15:0]    dest_q;
  logic [15:0]    ovf_q, ovf_d;
  logic           legal, reg_we, ovf_clr;
  logic [15:0]    rd;

  always_comb begin
    rd    = '0;
    legal = 1'b1;
    case (reg_addr)
      16'h0200: begin rd = 16'(XLEN);  legal = ~reg_write; end
      16'h0201: begin rd = 16'(NCH);   legal = ~reg_write; end
      16'h0202: begin rd = 16'(DEPTH); legal = ~reg_write; end
      16'h0203: rd = {15'b0, en_q};
      16'h0204: rd = 16'(mask_q);
      16'h0205: rd = dest_q;
      16'h0206: rd = ovf_q;
      default:  legal = 1'b0;
    endcase
    reg_ack   = reg_request & legal;
    reg_err   = reg_request & ~legal;
    reg_rdata = rd;
  end

  assign reg_we  = reg_request & reg_write & legal;
  assign ovf_clr = reg_we & (reg_addr == 16'h0206);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q   <= 1'b0;
      mask_q <= '1;
      dest_q <= '0;
      ovf_q  <= '0;
    end else begin
      if (reg_we && reg_addr == 16'h0203) en_q   <= reg_wdata[0];
      if (reg_we && reg_addr == 16'h0204) mask_q <= reg_wdata[NCH-1:0];
      if (reg_we && reg_addr == 16'h0205) dest_q <= reg_wdata;
      ovf_q <= ovf_d;
    end
  end

  // ---------------- capture / arbitration ----------------
  logic [NCH-1:0] elig;
  logic           gnt_vld, push, pop;
  logic [CHW-1:0] gnt_idx, ptr_q;
  logic [4:0]     nelig, ndrop;
  logic [16:0]    ovf_sum;
  logic [CW-1:0]  cnt_q, cnt_d;
  ev_t            gnt_ev;

  assign elig = trace_valid & mask_q & {NCH{en_q}};

  always_comb begin
    logic [CHW-1:0] idx;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    nelig   = '0;
    for (int i = 1; i <= NCH; i++) begin
      idx = CHW'((int'(ptr_q) + i) % NCH);
      if (!gnt_vld && elig[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx;
      end
    end
    for (int i = 0; i < NCH; i++) nelig = nelig + 5'(elig[i]);
  end

  // Space check uses the registered count only; a same-cycle pop frees nothing.
  assign push    = gnt_vld && (cnt_q < CW'(DEPTH));
  assign ndrop   = nelig - 5'(push);
  assign ovf_sum = {1'b0, ovf_q} + 17'(ndrop);
  assign ovf_d   = ovf_clr ? 16'h0000 : (ovf_sum[16] ? 16'hFFFF : ovf_sum[15:0]);

  always_comb begin
    gnt_ev.ch  = gnt_idx;
    gnt_ev.tid = trace_id[int'(gnt_idx)*16 +: 16];
    gnt_ev.val = trace_value[int'(gnt_idx)*XLEN +: XLEN];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       ptr_q <= CHW'(NCH - 1);
    else if (gnt_vld) ptr_q <= gnt_idx;
  end

  // ---------------- event FIFO ----------------
  ev_t           mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  ev_t           head;

  assign head  = mem_q[rd_q];
  assign cnt_d = cnt_q + CW'(push) - CW'(pop);

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= gnt_ev;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + AW'(1);
      if (pop)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_d;
    end
  end

  // ---------------- serializer ----------------
  state_t        state_q;
  logic [WW-1:0] wcnt_q;
  logic          valid_q, last_q;
  logic [15:0]   data;

  assign pop = (state_q == S_VAL) && last_q && event_out.ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      wcnt_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (cnt_q != '0) begin
          state_q <= S_DEST;
          valid_q <= 1'b1;
        end
        S_DEST: if (event_out.ready) state_q <= S_SRC;
        S_SRC:  if (event_out.ready) state_q <= S_TYPE;
        S_TYPE: if (event_out.ready) state_q <= S_TID;
        S_TID:  if (event_out.ready) begin
          state_q <= S_VAL;
          wcnt_q  <= '0;
          last_q  <= (NW == 1);
        end
        S_VAL:  if (event_out.ready) begin
          if (last_q) begin
            // Back-to-back packets skip IDLE when another entry is waiting.
            wcnt_q  <= '0;
            last_q  <= 1'b0;
            state_q <= (cnt_d != '0) ? S_DEST : S_IDLE;
            valid_q <= (cnt_d != '0);
          end else begin
            wcnt_q <= wcnt_q + WW'(1);
            last_q <= (int'(wcnt_q) == NW - 2);
          end
        end
        default: begin
          state_q <= S_IDLE;
          valid_q <= 1'b0;
          last_q  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    data = '0;
    case (state_q)
      S_DEST:  data = dest_q;
      S_SRC:   data = {6'b0, id};
      S_TYPE:  data = 16'h8000 | 16'(head.ch);
      S_TID:   data = head.tid;
      S_VAL:   data = head.val[int'(wcnt_q)*16 +: 16];
      default: data = '0;
    endcase
  end

  assign event_out.valid = valid_q;
  assign event_out.last  = last_q;
  assign event_out.data  = data;

endmodule

// File: tb/tb_osd_dp_trace_packetizer.sv
// Directed bench: register table plus hand-written packet, arbitration, overflow,
// stall and mid-packet reset sequences against two instances (DEPTH 8 and 4).
module tb_osd_dp_trace_packetizer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [9:0]   id;
  logic [3:0]   trace_valid;
  logic [63:0]  trace_id;
  logic [255:0] trace_value;
  logic         reg_request, reg_write;
  logic [15:0]  reg_addr, reg_wdata;
  logic         ack8, err8, ack4, err4;
  logic [15:0]  rdata8, rdata4;

  osd_dp_trace_packetizer_if ev8();
  osd_dp_trace_packetizer_if ev4();

  osd_dp_trace_packetizer #(.XLEN(64), .NCH(4), .DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .id(id), .trace_valid(trace_valid),
    .trace_id(trace_id), .trace_value(trace_value),
    .reg_request(reg_request), .reg_write(reg_write), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_ack(ack8), .reg_err(err8), .reg_rdata(rdata8),
    .event_out(ev8));

  osd_dp_trace_packetizer #(.XLEN(64), .NCH(4), .DEPTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .id(id), .trace_valid(trace_valid),
    .trace_id(trace_id), .trace_value(trace_value),
    .reg_request(reg_request), .reg_write(reg_write), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_ack(ack4), .reg_err(err4), .reg_rdata(rdata4),
    .event_out(ev4));

  always #5 clk = ~clk;

  int n_pass = 0, n_total = 0;
  logic        cap_ack, cap_err;
  logic [15:0] cap_rd8, cap_rd4;
  logic [15:0] flits[$];
  int          lastpos[$];

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        ack;
    logic        err;
    logic [15:0] rdata;
    logic        chk_rd;
    string       name;
  } rvec_t;
  rvec_t rv[21];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic reg_op(input logic wr, input logic [15:0] a, input logic [15:0] d);
    reg_request = 1'b1; reg_write = wr; reg_addr = a; reg_wdata = d;
    #1;
    cap_ack = ack8; cap_err = err8; cap_rd8 = rdata8; cap_rd4 = rdata4;
    step();
    reg_request = 1'b0; reg_write = 1'b0;
  endtask

  task automatic do_reset();
    trace_valid = '0; reg_request = 1'b0; reg_write = 1'b0;
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic setup(input logic [15:0] dest);
    do_reset();
    reg_op(1'b1, 16'h0205, dest);
    reg_op(1'b1, 16'h0203, 16'h0001);
  endtask

  // Drains dut flits until nlast packets end; optional 1/0 ready toggle with stability checks.
  task automatic run_sink(input int nlast, input bit toggle, input int budget, input string tag);
    int cyc = 0, lasts = 0;
    bit stalled = 0, r = 1;
    logic [15:0] sdata = '0;
    flits.delete(); lastpos.delete();
    while (lasts < nlast && cyc < budget) begin
      ev8.ready = r;
      #1;
      if (stalled) begin
        chk({tag, "_stall_valid"}, ev8.valid, 1'b1);
        chk({tag, "_stall_data"}, ev8.data, sdata);
      end
      if (ev8.valid && r) begin
        if (ev8.last) begin lasts++; lastpos.push_back(flits.size()); end
        flits.push_back(ev8.data);
        stalled = 0;
      end else if (ev8.valid) begin
        stalled = 1; sdata = ev8.data;
      end else stalled = 0;
      step();
      cyc++;
      if (toggle) r = ~r;
    end
    if (lasts < nlast) chk({tag, "_timeout"}, 64'(lasts), 64'(nlast));
  endtask

  initial begin
    logic [15:0] e031 [8];
    logic [15:0] e034 [8];
    int cnt, lasts4;

    rv[0]  = '{1'b0, 16'h0200, 16'h0000, 1'b1, 1'b0, 16'd64,   1'b1, "rd_xlen"};
    rv[1]  = '{1'b0, 16'h0201, 16'h0000, 1'b1, 1'b0, 16'd4,    1'b1, "rd_nch"};
    rv[2]  = '{1'b0, 16'h0202, 16'h0000, 1'b1, 1'b0, 16'd8,    1'b1, "rd_depth"};
    rv[3]  = '{1'b0, 16'h0203, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, "rst_ctrl"};
    rv[4]  = '{1'b0, 16'h0204, 16'h0000, 1'b1, 1'b0, 16'h000F, 1'b1, "rst_mask"};
    rv[5]  = '{1'b0, 16'h0205, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, "rst_dest"};
    rv[6]  = '{1'b0, 16'h0206, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, "rst_ovf"};
    rv[7]  = '{1'b1, 16'h0200, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b0, "wr_ro_xlen"};
    rv[8]  = '{1'b0, 16'h0300, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0, "rd_unmapped"};
    rv[9]  = '{1'b1, 16'h0202, 16'h0001, 1'b0, 1'b1, 16'h0000, 1'b0, "wr_ro_depth"};
    rv[10] = '{1'b0, 16'h0207, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0, "rd_207"};
    rv[11] = '{1'b1, 16'h0205, 16'h0010, 1'b1, 1'b0, 16'h0000, 1'b0, "wr_dest"};
    rv[12] = '{1'b0, 16'h0205, 16'h0000, 1'b1, 1'b0, 16'h0010, 1'b1, "rd_dest"};
    rv[13] = '{1'b1, 16'h0203, 16'hFFFF, 1'b1, 1'b0, 16'h0000, 1'b0, "wr_ctrl"};
    rv[14] = '{1'b0, 16'h0203, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b1, "rd_ctrl"};
    rv[15] = '{1'b1, 16'h0204, 16'hFFF3, 1'b1, 1'b0, 16'h0000, 1'b0, "wr_mask"};
    rv[16] = '{1'b0, 16'h0204, 16'h0000, 1'b1, 1'b0, 16'h0003, 1'b1, "rd_mask"};
    rv[17] = '{1'b1, 16'h0204, 16'h000F, 1'b1, 1'b0, 16'h0000, 1'b0, "wr_mask2"};
    rv[18] = '{1'b0, 16'h0204, 16'h0000, 1'b1, 1'b0, 16'h000F, 1'b1, "rd_mask2"};
    rv[19] = '{1'b1, 16'h0203, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, "wr_ctrl0"};
    rv[20] = '{1'b0, 16'h0203, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, "rd_ctrl0"};

    e031 = '{16'h0010, 16'h0005, 16'h8002, 16'h0042, 16'h7788, 16'h5566, 16'h3344, 16'h1122};
    e034 = '{16'h0010, 16'h0005, 16'h8001, 16'h0777, 16'hF00D, 16'hCAFE, 16'hBEEF, 16'hDEAD};

    id = 10'd5; trace_valid = '0; trace_id = '0; trace_value = '0;
    reg_request = 1'b0; reg_write = 1'b0; reg_addr = '0; reg_wdata = '0;
    ev8.ready = 1'b0; ev4.ready = 1'b0;
    rst_n = 1'b0;
    #2;
    chk("rst_valid", ev8.valid, 1'b0);
    chk("rst_last", ev8.last, 1'b0);
    do_reset();

    // Register map, table driven.
    foreach (rv[i]) begin
      reg_op(rv[i].wr, rv[i].addr, rv[i].wdata);
      chk({rv[i].name, "_ack"}, cap_ack, rv[i].ack);
      chk({rv[i].name, "_err"}, cap_err, rv[i].err);
      if (rv[i].chk_rd) chk({rv[i].name, "_rdata"}, cap_rd8, rv[i].rdata);
    end
    reg_op(1'b0, 16'h0202, 16'h0000);
    chk("rd_depth4", cap_rd4, 16'd4);
    reg_write = 1'b1; reg_addr = 16'h0200; #1;
    chk("noreq_ack", ack8, 1'b0);
    chk("noreq_err", err8, 1'b0);
    reg_write = 1'b0;
    step();

    // Single event: latency and flit content.
    setup(16'h0010);
    trace_id[47:32] = 16'h0042;
    trace_value[191:128] = 64'h1122334455667788;
    trace_valid = 4'b0100; ev8.ready = 1'b1;
    #1 chk("lat_c0", ev8.valid, 1'b0);
    step(); trace_valid = '0;
    #1 chk("lat_c1", ev8.valid, 1'b0);
    step();
    #1 chk("lat_c2", ev8.valid, 1'b1);
    run_sink(1, 1'b0, 40, "pkt");
    chk("pkt_len", flits.size(), 8);
    for (int i = 0; i < 8 && i < flits.size(); i++) chk($sformatf("pkt_flit%0d", i), flits[i], e031[i]);
    chk("pkt_nlast", lastpos.size(), 1);
    if (lastpos.size() > 0) chk("pkt_lastpos", lastpos[0], 7);
    #1 chk("pkt_idle", ev8.valid, 1'b0);
    step();

    // All channels every cycle: round-robin order and overflow count.
    setup(16'h0010);
    trace_id    = {16'h0103, 16'h0102, 16'h0101, 16'h0100};
    trace_value = {64'hA003, 64'hA002, 64'hA001, 64'hA000};
    ev8.ready = 1'b0; ev4.ready = 1'b1;
    trace_valid = 4'hF;
    repeat (4) step();
    trace_valid = '0;
    run_sink(4, 1'b0, 200, "rr");
    chk("rr_len", flits.size(), 32);
    for (int k = 0; k < 4 && flits.size() >= 32; k++) begin
      chk($sformatf("rr_type%0d", k), flits[8*k+2], 16'h8000 + 16'(k));
      chk($sformatf("rr_tid%0d", k), flits[8*k+3], 16'h0100 + 16'(k));
      chk($sformatf("rr_val%0d", k), flits[8*k+4], 16'hA000 + 16'(k));
    end
    chk("rr_nlast", lastpos.size(), 4);
    reg_op(1'b0, 16'h0206, 16'h0000);
    chk("rr_ovf", cap_rd8, 16'd12);

    // DEPTH=4 instance: fill while stalled, overflow, clear-wins, drain.
    setup(16'h0010);
    ev8.ready = 1'b0; ev4.ready = 1'b0;
    trace_valid = 4'b0001;
    repeat (6) step();
    trace_valid = '0;
    reg_op(1'b0, 16'h0206, 16'h0000);
    chk("full_ovf", cap_rd4, 16'd2);
    trace_valid = 4'b0001;
    reg_op(1'b1, 16'h0206, 16'h0000);
    chk("clr_ack", cap_ack, 1'b1);
    trace_valid = '0;
    reg_op(1'b0, 16'h0206, 16'h0000);
    chk("clr_wins", cap_rd4, 16'd0);
    ev4.ready = 1'b1;
    lasts4 = 0;
    for (int c = 0; c < 80; c++) begin
      #1 if (ev4.valid && ev4.last) lasts4++;
      step();
    end
    chk("full_stored", lasts4, 4);
    chk("full_drained", ev4.valid, 1'b0);

    // Ready toggling each cycle.
    setup(16'h0010);
    trace_id[31:16] = 16'h0777;
    trace_value[127:64] = 64'hDEADBEEFCAFEF00D;
    trace_valid = 4'b0010;
    step();
    trace_valid = '0;
    run_sink(1, 1'b1, 60, "tog");
    chk("tog_len", flits.size(), 8);
    for (int i = 0; i < 8 && i < flits.size(); i++) chk($sformatf("tog_flit%0d", i), flits[i], e034[i]);
    chk("tog_nlast", lastpos.size(), 1);

    // Reset in the middle of a packet with entries queued behind it.
    setup(16'h0010);
    ev8.ready = 1'b1;
    trace_valid = 4'b0001;
    repeat (3) step();
    trace_valid = '0;
    step();
    chk("mid_third", ev8.data, 16'h8000);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", ev8.valid, 1'b0);
    chk("mid_rst_last", ev8.last, 1'b0);
    step(); step();
    rst_n = 1'b1;
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (ev8.valid) cnt++;
    end
    chk("mid_no_flits", cnt, 0);
    reg_op(1'b0, 16'h0203, 16'h0000);
    chk("mid_ctrl", cap_rd8, 16'h0000);
    reg_op(1'b1, 16'h0203, 16'h0001);
    trace_valid = 4'b1000;
    step();
    trace_valid = '0;
    run_sink(1, 1'b0, 40, "mid_new");
    chk("mid_new_type", (flits.size() > 2) ? flits[2] : 16'h0, 16'h8003);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
